// File: rtl/noc_pkg.sv
// Shared router-node types and constants: flit layout and port numbering.
package noc_pkg;
    localparam int FLIT_W     = 11;
    localparam int ADDR_W     = 4;
    localparam int PAYLOAD_W  = 7;
    localparam int NUM_PORTS  = 5;
    localparam int LOCAL_PORT = 4;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [2:0]        port_id_t;
endpackage

// File: rtl/router_port_arbiter_fifo_rr_arbiter.sv
// Round-robin arbiter: combinational grant from ptr; ptr moves past the winner on accept.
// Zero latency; no grant while en is low, and ptr then holds.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    logic [IDX_W-1:0] ptr_q, ptr_d;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (en && req[wrap_add(ptr_q, k)]) begin
                gnt                    = '0;
                gnt[wrap_add(ptr_q, k)] = 1'b1;
                gnt_idx                = wrap_add(ptr_q, k);
                gnt_vld                = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/router_port_arbiter_fifo.sv
// Output-port stage: round-robin merge of NUM_IN requesters into a DEPTH-entry flit FIFO.
// Accepted flit visible on out_* one edge later; a full FIFO drops every in_ready to 0.
module router_port_arbiter_fifo #(
    parameter int NUM_IN = noc_pkg::NUM_PORTS,
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = 2,
    parameter int SRC_W  = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_IN-1:0]          in_valid,
    input  logic [NUM_IN*FLIT_W-1:0]   in_data,
    output logic [NUM_IN-1:0]          in_ready,
    output logic                       out_valid,
    output logic [FLIT_W-1:0]          out_data,
    output logic [SRC_W-1:0]           out_src,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);
    import noc_pkg::*;

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [FLIT_W-1:0] dat;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               can_push;
    logic [NUM_IN-1:0]  gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic [FLIT_W-1:0]  flit_sel;
    logic               push;
    logic               pop;

    // can_push depends only on registered count, so out_ready never reaches in_ready.
    assign can_push = (count_q < CNT_W'(DEPTH)) && !RESET;

    rr_arbiter #(.N(NUM_IN), .IDX_W(IDX_W)) u_arb (
        .clk     (CLK),
        .rst     (RESET),
        .req     (in_valid),
        .en      (can_push),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        flit_sel = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) flit_sel = flit_sel | in_data[i*FLIT_W +: FLIT_W];
        end
    end

    assign in_ready  = gnt;
    assign push      = gnt_vld;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q].dat;
    assign out_src   = mem_q[rd_ptr_q].src;
    assign occupancy = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{src: SRC_W'(gnt_idx), dat: flit_sel};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_router_port_arbiter_fifo.sv
// Directed bench for router_port_arbiter_fifo: reset, single flit, round-robin, stall, mid reset, push+pop.
module tb_router_port_arbiter_fifo;
    localparam int NUM_IN = 5;
    localparam int FLIT_W = 11;
    localparam int DEPTH  = 2;
    localparam int SRC_W  = 3;

    logic                     CLK;
    logic                     RESET;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*FLIT_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [FLIT_W-1:0]        out_data;
    logic [SRC_W-1:0]         out_src;
    logic                     out_ready;
    logic [1:0]               occupancy;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    router_port_arbiter_fifo #(
        .NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .DEPTH(DEPTH), .SRC_W(SRC_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [FLIT_W-1:0] rr_flit(input int i);
        return FLIT_W'(i * 128 + i * 3 + 1);
    endfunction

    task automatic set_flit(input int i, input logic [FLIT_W-1:0] v);
        in_data[i*FLIT_W +: FLIT_W] = v;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        next_cycle();
        RESET     = 1'b0;
    endtask

    task automatic test_reset();
        RESET     = 1'b1;
        in_valid  = '1;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (in_ready !== 5'b00000) begin
            $display("FAIL reset_in_ready got=%b exp=00000", in_ready); fails++;
        end else passed++;
        next_cycle();
        in_valid = '0;
        @(negedge CLK);
        checks++;
        if ({out_valid, out_data, out_src, occupancy} !== '0) begin
            $display("FAIL reset_outputs got vld=%b dat=%h src=%0d occ=%0d exp all 0",
                     out_valid, out_data, out_src, occupancy); fails++;
        end else passed++;
        next_cycle();
        RESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 5'b00000) begin
                $display("FAIL idle_cycle%0d got vld=%b occ=%0d rdy=%b exp 0/0/00000",
                         c, out_valid, occupancy, in_ready); fails++;
            end else passed++;
            next_cycle();
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        set_flit(2, 11'h5A3);
        in_valid  = 5'b00100;
        @(negedge CLK);
        checks++;
        if (in_ready !== 5'b00100) begin
            $display("FAIL single_in_ready got=%b exp=00100", in_ready); fails++;
        end else passed++;
        next_cycle();
        in_valid = '0;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h5A3 || out_src !== 3'd2) begin
            $display("FAIL single_head got vld=%b dat=%h src=%0d exp 1/5a3/2",
                     out_valid, out_data, out_src); fails++;
        end else passed++;
        next_cycle();
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            $display("FAIL single_drain got vld=%b occ=%0d exp 0/0", out_valid, occupancy); fails++;
        end else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) set_flit(i, rr_flit(i));
        in_valid = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            checks++;
            if (in_ready !== 5'(1 << (c % 5))) begin
                $display("FAIL rr_grant%0d got=%b exp=%b", c, in_ready, 5'(1 << (c % 5))); fails++;
            end else passed++;
            if (c > 0) begin
                checks++;
                if (occupancy !== 2'd1 || out_src !== 3'((c - 1) % 5) ||
                    out_data !== rr_flit((c - 1) % 5)) begin
                    $display("FAIL rr_head%0d got occ=%0d src=%0d dat=%h exp 1/%0d/%h",
                             c, occupancy, out_src, out_data, (c - 1) % 5, rr_flit((c - 1) % 5));
                    fails++;
                end else passed++;
            end
            next_cycle();
        end
        in_valid = '0;
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        set_flit(0, 11'h011);
        set_flit(3, 11'h1B3);
        in_valid = 5'b01001;
        @(negedge CLK);
        checks++;
        if (in_ready !== 5'b00001) begin
            $display("FAIL stall_grant0 got=%b exp=00001", in_ready); fails++;
        end else passed++;
        next_cycle();
        @(negedge CLK);
        checks++;
        if (in_ready !== 5'b01000) begin
            $display("FAIL stall_grant3 got=%b exp=01000", in_ready); fails++;
        end else passed++;
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++;
            if (in_ready !== 5'b00000 || occupancy !== 2'd2 || out_src !== 3'd0) begin
                $display("FAIL stall_full%0d got rdy=%b occ=%0d src=%0d exp 00000/2/0",
                         c, in_ready, occupancy, out_src); fails++;
            end else passed++;
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (in_ready !== 5'b00000 || out_data !== 11'h011) begin
            $display("FAIL stall_release got rdy=%b dat=%h exp 00000/011", in_ready, out_data); fails++;
        end else passed++;
        next_cycle();
        @(negedge CLK);
        checks++;
        if (out_src !== 3'd3 || out_data !== 11'h1B3 || in_ready !== 5'b00001) begin
            $display("FAIL stall_pop1 got src=%0d dat=%h rdy=%b exp 3/1b3/00001",
                     out_src, out_data, in_ready); fails++;
        end else passed++;
        next_cycle();
        in_valid = '0;
        @(negedge CLK);
        checks++;
        if (out_src !== 3'd0 || occupancy !== 2'd1) begin
            $display("FAIL stall_regrant got src=%0d occ=%0d exp 0/1", out_src, occupancy); fails++;
        end else passed++;
        next_cycle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_flit(0, 11'h0A0);
        set_flit(2, 11'h2A2);
        set_flit(3, 11'h3A3);
        in_valid = 5'b00101;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        checks++;
        if (occupancy !== 2'd2) begin
            $display("FAIL midrst_fill got occ=%0d exp 2", occupancy); fails++;
        end else passed++;
        next_cycle();
        RESET    = 1'b1;
        in_valid = 5'b01001;
        @(negedge CLK);
        checks++;
        if (in_ready !== 5'b00000) begin
            $display("FAIL midrst_in_ready got=%b exp=00000", in_ready); fails++;
        end else passed++;
        next_cycle();
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 5'b00001) begin
            $display("FAIL midrst_after got vld=%b occ=%0d rdy=%b exp 0/0/00001",
                     out_valid, occupancy, in_ready); fails++;
        end else passed++;
        next_cycle();
        in_valid = '0;
        next_cycle();
    endtask

    task automatic test_push_pop();
        do_reset();
        set_flit(1, 11'h1C1);
        set_flit(4, 11'h64E);
        in_valid = 5'b00010;
        next_cycle();
        in_valid  = 5'b10000;
        out_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (occupancy !== 2'd1 || in_ready !== 5'b10000 || out_src !== 3'd1) begin
            $display("FAIL pp_before got occ=%0d rdy=%b src=%0d exp 1/10000/1",
                     occupancy, in_ready, out_src); fails++;
        end else passed++;
        next_cycle();
        in_valid = '0;
        @(negedge CLK);
        checks++;
        if (occupancy !== 2'd1 || out_src !== 3'd4 || out_data !== 11'h64E) begin
            $display("FAIL pp_after got occ=%0d src=%0d dat=%h exp 1/4/64e",
                     occupancy, out_src, out_data); fails++;
        end else passed++;
        next_cycle();
    endtask

    initial begin
        RESET     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_mid_reset();
        test_push_pop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout after 100000 time units");
        $fatal(1, "bench did not finish");
    end
endmodule
